multiplicador_serie: RTL and testbench



---
 rtl/multiplicador_serie_if.sv | 19 +
 rtl/multiplicador_serie.sv | 121 ++++++++++++
 tb/tb_multiplicador_serie.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/multiplicador_serie_if.sv
// Start/busy/done handshake and operand/product bus of the serial signed multiplier.
// The master side issues operands; the slave side is the multiplier itself.
interface multiplicador_serie_if #(
   parameter int cant_bits = 25,
   parameter int ent       = 10,
   parameter int frac      = 14
);
   localparam int PW = 2*ent + 2*frac + 1;

   logic                  start;
   logic signed [cant_bits-1:0] a;
   logic signed [cant_bits-1:0] b;
   logic                  busy;
   logic                  done;
   logic signed [PW-1:0]  product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/multiplicador_serie.sv
// Shift-add signed Qent.frac multiplier: magnitude multiply, then sign fix and saturation.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands finish in one cycle without going busy.
module multiplicador_serie #(
   parameter int cant_bits = 25,
   parameter int ent       = 10,
   parameter int frac      = 14
) (
   input logic clk,
   input logic reset,
   multiplicador_serie_if.slave bus
);
   localparam int PW = 2*ent + 2*frac + 1;
   localparam int AW = 2*cant_bits;
   localparam int CW = $clog2(cant_bits + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t               state_q;
   logic [cant_bits-1:0] mcand_q;
   logic [cant_bits-1:0] mplier_q;
   logic [AW-1:0]        acc_q;
   logic                 sign_q;
   logic [CW-1:0]        count_q;
   logic                 busy_q;
   logic                 done_q;
   logic [PW-1:0]        product_q;

   logic [cant_bits-1:0] aRaw_d, bRaw_d, magA_d, magB_d;
   logic [cant_bits:0]   sum_d;
   logic [AW-1:0]        accShift_d;
   logic [AW-1:0]        accNeg_d;
   logic [PW-1:0]        fixed_d;
   logic                 bypass_d;

   // Unsigned magnitudes; the most negative operand maps to 2^(cant_bits-1), which still fits.
   always_comb begin
      aRaw_d = bus.a;
      bRaw_d = bus.b;
      magA_d = aRaw_d[cant_bits-1] ? (~aRaw_d + cant_bits'(1)) : aRaw_d;
      magB_d = bRaw_d[cant_bits-1] ? (~bRaw_d + cant_bits'(1)) : bRaw_d;
`ifdef MULT_ZERO_BYPASS_EN
      bypass_d = (aRaw_d == '0) || (bRaw_d == '0);
`else
      bypass_d = 1'b0;
`endif
   end

   // One shift-add step: the carry out of the upper half becomes the new MSB after the shift.
   always_comb begin
      sum_d      = {1'b0, acc_q[AW-1:cant_bits]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      accShift_d = {sum_d, acc_q[cant_bits-1:1]};
   end

   // Only |min|*|min| overflows the positive range; every negative product fits exactly.
   always_comb begin
      accNeg_d = ~acc_q + AW'(1);
      fixed_d  = '0;
      if (sign_q) begin
         fixed_d = accNeg_d[PW-1:0];
      end else if (acc_q[AW-1:PW-1] != '0) begin
         fixed_d = {1'b0, {(PW-1){1'b1}}};
      end else begin
         fixed_d = acc_q[PW-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         sign_q    <= 1'b0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start && bypass_d) begin
                  product_q <= '0;
                  done_q    <= 1'b1;
               end else if (bus.start) begin
                  mcand_q  <= magA_d;
                  mplier_q <= magB_d;
                  sign_q   <= aRaw_d[cant_bits-1] ^ bRaw_d[cant_bits-1];
                  acc_q    <= '0;
                  count_q  <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= CALC;
               end
            end
            CALC: begin
               acc_q    <= accShift_d;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + CW'(1);
               if (count_q == CW'(cant_bits - 1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               product_q <= fixed_d;
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_multiplicador_serie.sv
// Scoreboard bench for multiplicador_serie: the driver queues expected products and a
// negedge monitor pops and compares them on every done pulse.
module tb_multiplicador_serie;
   localparam int CB   = 25;
   localparam int ENT  = 10;
   localparam int FRAC = 14;
   localparam int PW   = 2*ENT + 2*FRAC + 1;
   localparam int LAT  = CB + 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int total     = 0;
   int bad       = 0;
   int doneCount = 0;

   logic signed [PW-1:0] expQ[$];
   logic signed [PW-1:0] monExp;

   always #5 clk = ~clk;

   multiplicador_serie_if #(.cant_bits(CB), .ent(ENT), .frac(FRAC)) bus ();

   multiplicador_serie #(.cant_bits(CB), .ent(ENT), .frac(FRAC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic checkOutput(input string name, input longint actual, input longint required);
      total++;
      if (actual != required) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
      end
   endtask

   // Reference product from the signed operands, clamped to the positive product range.
   function automatic logic signed [PW-1:0] model(input logic signed [CB-1:0] x,
                                                  input logic signed [CB-1:0] y);
      longint p;
      longint maxPos;
      maxPos = (64'sd1 <<< (PW-1)) - 64'sd1;
      p = longint'(x) * longint'(y);
      if (p > maxPos) p = maxPos;
      return PW'(p);
   endfunction

   // Every done pulse outside reset must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && bus.done) begin
         doneCount++;
         if (expQ.size() == 0) begin
            checkOutput("spurious done", 1, 0);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("product", longint'(bus.product), longint'(monExp));
         end
      end
   end

   // One operation: scramble operands after acceptance and poke start while busy.
   task automatic applyStimulus(input logic signed [CB-1:0] aIn,
                                input logic signed [CB-1:0] bIn,
                                input longint expProd,
                                input int expLat,
                                input int expBusy);
      int cyc;
      int busyCyc;
      cyc     = 0;
      busyCyc = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = aIn;
      bus.b     = bIn;
      expQ.push_back(PW'(expProd));
      do begin
         @(negedge clk);
         cyc++;
         bus.start = (cyc == 5);
         bus.a     = ~aIn;
         bus.b     = ~bIn;
         if (bus.done) break;
         if (bus.busy) busyCyc++;
      end while (cyc < 60);
      bus.start = 1'b0;
      checkOutput("latency", cyc, expLat);
      checkOutput("busy cycles", busyCyc, expBusy);
      checkOutput("busy at done", longint'(bus.busy), 0);
      @(negedge clk);
      checkOutput("done pulse width", longint'(bus.done), 0);
   endtask

   initial begin
      int dc0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("reset busy", longint'(bus.busy), 0);
      checkOutput("reset done", longint'(bus.done), 0);
      checkOutput("reset product", longint'(bus.product), 0);

      applyStimulus(25'sd24576, 25'sd32768, 64'sd805306368, LAT, LAT-1);
      applyStimulus(-25'sd16384, 25'sd40960, -64'sd671088640, LAT, LAT-1);
      applyStimulus(25'sd40960, -25'sd16384, -64'sd671088640, LAT, LAT-1);
      applyStimulus(-25'sd16777216, -25'sd16777216, 64'sd281474976710655, LAT, LAT-1);
      applyStimulus(-25'sd16777216, 25'sd16384, -64'sd274877906944, LAT, LAT-1);
      applyStimulus(25'sd3, -25'sd1, -64'sd3, LAT, LAT-1);

      // Start held high: only edges 0, 27 and 54 of this window are acceptances.
      dc0 = doneCount;
      for (int i = 0; i < 3*LAT; i++) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.a     = CB'(i*1234567 + 4321);
         bus.b     = CB'(7654321 - i*333333);
         if (i % LAT == 0) expQ.push_back(model(bus.a, bus.b));
      end
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("back-to-back done count", doneCount - dc0, 3);

      // Abort an operation around iteration 10; nothing may complete afterwards.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 25'sd3;
      bus.b     = 25'sd5;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      expQ.delete();
      #1;
      checkOutput("abort busy", longint'(bus.busy), 0);
      checkOutput("abort done", longint'(bus.done), 0);
      checkOutput("abort product", longint'(bus.product), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      dc0 = doneCount;
      repeat (40) @(negedge clk);
      checkOutput("no done after abort", doneCount - dc0, 0);

`ifdef MULT_ZERO_BYPASS_EN
      applyStimulus(25'sd0, 25'sd12345, 64'sd0, 1, 0);
`else
      applyStimulus(25'sd0, 25'sd12345, 64'sd0, LAT, LAT-1);
`endif
      applyStimulus(-25'sd7, 25'sd0,
                    64'sd0,
`ifdef MULT_ZERO_BYPASS_EN
                    1, 0);
`else
                    LAT, LAT-1);
`endif

      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
